// File: rtl/transport_receive_if.sv
// Byte-stream input and FWFT output bundle of the transport receive stage.
interface transport_receive_if;
    logic        sending;
    logic [7:0]  packetIn;
    logic        outReady;
    logic        outValid;
    logic [1:0]  outCmd;
    logic [15:0] outData;
    logic        frameErr;
    logic        overflow;
    logic [7:0]  errCount;
    logic        busy;

    modport slave (
        input  sending, packetIn, outReady,
        output outValid, outCmd, outData, frameErr, overflow, errCount, busy
    );

    modport master (
        output sending, packetIn, outReady,
        input  outValid, outCmd, outData, frameErr, overflow, errCount, busy
    );
endinterface

// File: rtl/transport_receive.sv
// Transport receive stage: frame delineation, header/timeout checks and FWFT queue of {cmd,data}.
// Optional trailing XOR checksum byte is enabled with `define TRANSPORT_CHECKSUM_EN.
module transport_receive #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    transport_receive_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_CHK} state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [15:0]        data_q, data_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             head_q, head_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         errcnt_q, errcnt_d;
    logic               busy_q, busy_d;
    logic               commit, push, pop, full, timeout;
    logic [8:0]         err_sum;
    entry_t             wdata;
`ifdef TRANSPORT_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
`endif

    // Frame parser and inter-byte gap supervision
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        ferr_d  = 1'b0;
        commit  = 1'b0;
`ifdef TRANSPORT_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        timeout = (state_q != S_IDLE) && (gap_q == GAP_W'(TIMEOUT));
        if (timeout) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
        end else if (bus.sending) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.packetIn[7:2] == 6'b101000 && bus.packetIn[1:0] != 2'b00) begin
                        cmd_d   = bus.packetIn[1:0];
                        state_d = S_HI;
`ifdef TRANSPORT_CHECKSUM_EN
                        xor_d   = bus.packetIn;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                S_HI: begin
                    data_d[15:8] = bus.packetIn;
                    state_d      = S_LO;
`ifdef TRANSPORT_CHECKSUM_EN
                    xor_d        = xor_q ^ bus.packetIn;
`endif
                end
                S_LO: begin
                    data_d[7:0] = bus.packetIn;
`ifdef TRANSPORT_CHECKSUM_EN
                    xor_d       = xor_q ^ bus.packetIn;
                    state_d     = S_CHK;
`else
                    commit      = 1'b1;
                    state_d     = S_IDLE;
`endif
                end
`ifdef TRANSPORT_CHECKSUM_EN
                S_CHK: begin
                    if (bus.packetIn == xor_q) commit = 1'b1;
                    else                       ferr_d = 1'b1;
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        gap_d  = (state_d == S_IDLE || bus.sending) ? '0 : GAP_W'(gap_q + 1'b1);
        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        wdata   = '{cmd: cmd_d, data: data_d};
        pop     = bus.outReady && (count_q != '0);
        full    = (count_q == CNT_W'(DEPTH));
        push    = commit && (!full || pop);
        ovf_d   = commit && !push;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        head_d  = head_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = FIFO_AW'(wptr_q + 1'b1);
        end
        if (pop) rptr_d = FIFO_AW'(rptr_q + 1'b1);
        case ({push, pop})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
        if (pop) begin
            if (count_q > CNT_W'(1)) head_d = mem_q[FIFO_AW'(rptr_q + 1'b1)];
            else if (push)           head_d = wdata;
        end else if (push && count_q == '0) begin
            head_d = wdata;
        end
        valid_d  = (count_d != '0);
        err_sum  = 9'(errcnt_q) + 9'(ferr_d) + 9'(ovf_d);
        errcnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            cmd_q    <= '0;
            data_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            errcnt_q <= '0;
            busy_q   <= 1'b0;
`ifdef TRANSPORT_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            errcnt_q <= errcnt_d;
            busy_q   <= busy_d;
`ifdef TRANSPORT_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    assign bus.outValid = valid_q;
    assign bus.outCmd   = head_q.cmd;
    assign bus.outData  = head_q.data;
    assign bus.frameErr = ferr_q;
    assign bus.overflow = ovf_q;
    assign bus.errCount = errcnt_q;
    assign bus.busy     = busy_q;
endmodule

// File: doc/transport_receive.md
# transport_receive

Receive-side transport stage: consumes the byte stream produced by the transport sender, strobed by its `sending` flag and carried on its 8-bit `packetOut`. Delineates frames, checks header and optional checksum, and recovers each frame's `cmd`/`data` pair. Accepted pairs are queued in a small first-word-fall-through FIFO for the application layer (audio playback / call control). Malformed, timed-out and overflowing frames are flagged and counted.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW entries of 18 bits {cmd,data}.
- `TIMEOUT`, 15: maximum idle cycles allowed between bytes of one frame.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; one clock, reset is asynchronous and active-low.
- `sending` in 1: byte strobe; `packetIn` is valid on every cycle it is high.
- `packetIn` in 8: received byte.
- `outReady` in 1: consumer pops the head entry when `outReady && outValid`.
- `outValid` out 1: FIFO non-empty.
- `outCmd` out 2: head entry command.
- `outData` out 16: head entry data.
- `frameErr` out 1: one-cycle pulse on header, checksum or timeout error.
- `overflow` out 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- `errCount` out 8: saturating count (stops at 255) of `frameErr` plus `overflow` events.
- `busy` out 1: high while the state machine is not IDLE.

## Operation
- Frame format: header `{4'b1010, 2'b00, cmd[1:0]}`, then `data[15:8]`, then `data[7:0]`, then (macro only) checksum = XOR of the three preceding bytes.
- States: IDLE → HI → LO → (CHK) → IDLE.
  - IDLE: a byte with upper six bits `101000` and `cmd != 2'b00` is a header; latch `cmd` and go to HI.
  - IDLE: any other byte pulses `frameErr` and stays in IDLE; `cmd == 2'b00` is an error.
  - HI: latch `data[15:8]`, go to LO.
  - LO: latch `data[7:0]`. Go to CHK when the macro is defined; otherwise commit.
  - CHK: compare the byte with the running XOR. Match commits; mismatch pulses `frameErr`. Either way return to IDLE.
- Commit means push {cmd,data} into the FIFO and return to IDLE.
  - If the FIFO is full and no pop occurs that cycle, drop the frame and pulse `overflow`.
  - A push and a pop in the same cycle on a full FIFO are both accepted; occupancy is unchanged.
- Gap counter:
  - Clears on every strobed byte and increments each non-IDLE cycle with `sending` low.
  - When it reaches `TIMEOUT`, pulse `frameErr`, discard the partial frame and return to IDLE.
  - A byte arriving on that same cycle is not accepted.
- FIFO pointers wrap modulo depth, with a separate count register of FIFO_AW+1 bits.
- Reset values:
  - State IDLE; FIFO empty; all latches 0.
  - `outValid`, `frameErr`, `overflow`, `busy` are 0.
  - `outCmd`, `outData` are 0.
  - `errCount` is 0.
- Reset asserted mid-frame aborts the frame. FIFO contents are lost.

## Timing
- Bytes may arrive back-to-back, one per cycle; no backpressure is applied to the sender.
- Commit on the final byte's edge N: `outValid` is high after edge N, visible in cycle N+1, if the FIFO was empty.
  - Header-to-`outValid` latency is 3 cycles, or 4 with the checksum, for back-to-back bytes.
- `frameErr` and `overflow` are registered, high for exactly the cycle after the offending edge.
- `errCount` updates on the same edge that raises the pulse. When both pulses occur on the same edge, it increments by 2, saturating.
- `outCmd`/`outData` change only on a pop or a push into an empty FIFO.
- `busy` is high from the cycle after a header is accepted until return to IDLE.

## Configuration
- `TRANSPORT_CHECKSUM_EN`:
  - Defined: frames are 4 bytes, CHK state present, checksum mismatch is an error.
  - Undefined: frames are 3 bytes, no CHK state, no XOR logic.
  - The sender must be built with the same setting.

## Test plan
- Reset, then send frame 0xA2,0x80,0x01 back-to-back (plus 0x23 if checksum enabled) → `outValid`=1, `outCmd`=2'b10, `outData`=16'h8001 at the latency above; pop with `outReady` → `outValid`=0.
- Header byte 0xA0, then 0x55 → two single-cycle `frameErr` pulses, `errCount`=2, FIFO stays empty.
- Header 0xA1, one-byte gap of 15 idle cycles → `frameErr` pulse, `busy` falls; next valid frame is received correctly.
- `outReady`=0, FIFO_AW=3, send 9 valid frames → 8 stored in order, 9th pulses `overflow`, `errCount`=1; full FIFO with simultaneous pop and push → count stays 8, order preserved.
- Checksum enabled, frame 0xA1,0x12,0x34 with checksum 0x00 (correct 0x87) → `frameErr` pulse, nothing pushed.
- Assert `reset` low during the LO state → `busy`=0 and `outValid`=0 immediately; after release, a full frame decodes normally.
